// File: rtl/fw_weight_seq.sv
// fw_weight_seq: streams binary-weight rows from a combinational ROM to a
// ready/valid consumer, repeating a window of num_words rows num_passes times.
// Optional feature macro: FW_SEQ_POPCNT_EN adds a registered popcount of
// each emitted word on w_popcnt.
module fw_weight_seq #(
   parameter int WIDTH_A = 12,
   parameter int DEPTH   = 80,
   parameter int WIDTH_D = 40
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   input  logic [WIDTH_A-1:0] base_addr,
   input  logic [WIDTH_A-1:0] num_words,
   input  logic [7:0]         num_passes,
   output logic [WIDTH_A-1:0] rom_addr,
   input  logic [WIDTH_D-1:0] rom_coef,
   output logic [WIDTH_D-1:0] w_data,
   output logic               w_valid,
   input  logic               w_ready,
   output logic               w_last,
   output logic               busy,
   output logic               done
`ifdef FW_SEQ_POPCNT_EN
   ,
   output logic [5:0]         w_popcnt
`endif
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

   state_e               state_q, state_d;
   logic [WIDTH_A-1:0]   rom_addr_q, rom_addr_d;
   logic [WIDTH_A-1:0]   base_q, base_d;
   logic [WIDTH_A-1:0]   nwords_q, nwords_d;
   logic [7:0]           npasses_q, npasses_d;
   logic [WIDTH_A-1:0]   word_cnt_q, word_cnt_d;
   logic [7:0]           pass_cnt_q, pass_cnt_d;
   logic [WIDTH_D-1:0]   w_data_q, w_data_d;
   logic                 w_valid_q, w_valid_d;
   logic                 w_last_q, w_last_d;
   logic                 done_q, done_d;
   logic                 load;
   logic [WIDTH_A-1:0]   base_mod;
   logic                 word_last, pass_last;

   // Out-of-range base addresses fold back into the ROM.
   assign base_mod  = WIDTH_A'(32'(base_addr) % DEPTH);
   assign word_last = (word_cnt_q == nwords_q - WIDTH_A'(1));
   assign pass_last = (pass_cnt_q == npasses_q - 8'd1);

   // Next-state and datapath decisions; abort outranks the handshake.
   always_comb begin
      state_d    = state_q;
      rom_addr_d = rom_addr_q;
      base_d     = base_q;
      nwords_d   = nwords_q;
      npasses_d  = npasses_q;
      word_cnt_d = word_cnt_q;
      pass_cnt_d = pass_cnt_q;
      w_data_d   = w_data_q;
      w_valid_d  = w_valid_q;
      w_last_d   = w_last_q;
      done_d     = 1'b0;
      load       = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (num_words == '0 || num_passes == '0) begin
                  // Empty job: acknowledge immediately, emit nothing.
                  done_d = 1'b1;
               end else begin
                  base_d     = base_mod;
                  nwords_d   = num_words;
                  npasses_d  = num_passes;
                  rom_addr_d = base_mod;
                  word_cnt_d = '0;
                  pass_cnt_d = '0;
                  state_d    = RUN;
               end
            end
         end
         RUN: begin
            if (abort) begin
               state_d   = IDLE;
               w_valid_d = 1'b0;
               w_last_d  = 1'b0;
            end else if (!w_valid_q || w_ready) begin
               load      = 1'b1;
               w_data_d  = rom_coef;
               w_valid_d = 1'b1;
               w_last_d  = word_last;
               if (word_last) begin
                  // Restart the window for the next pass without a bubble.
                  word_cnt_d = '0;
                  rom_addr_d = base_q;
                  if (pass_last) state_d = DRAIN;
                  else           pass_cnt_d = pass_cnt_q + 8'd1;
               end else begin
                  word_cnt_d = word_cnt_q + WIDTH_A'(1);
                  rom_addr_d = (rom_addr_q == WIDTH_A'(DEPTH - 1)) ? '0
                                                                  : rom_addr_q + WIDTH_A'(1);
               end
            end
         end
         DRAIN: begin
            if (abort) begin
               state_d   = IDLE;
               w_valid_d = 1'b0;
               w_last_d  = 1'b0;
            end else if (w_ready) begin
               state_d   = IDLE;
               w_valid_d = 1'b0;
               w_last_d  = 1'b0;
               done_d    = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         rom_addr_q <= '0;
         base_q     <= '0;
         nwords_q   <= '0;
         npasses_q  <= '0;
         word_cnt_q <= '0;
         pass_cnt_q <= '0;
         w_data_q   <= '0;
         w_valid_q  <= 1'b0;
         w_last_q   <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rom_addr_q <= rom_addr_d;
         base_q     <= base_d;
         nwords_q   <= nwords_d;
         npasses_q  <= npasses_d;
         word_cnt_q <= word_cnt_d;
         pass_cnt_q <= pass_cnt_d;
         w_data_q   <= w_data_d;
         w_valid_q  <= w_valid_d;
         w_last_q   <= w_last_d;
         done_q     <= done_d;
      end
   end

`ifdef FW_SEQ_POPCNT_EN
   logic [5:0] popcnt_q, popcnt_d;

   // Popcount of the ROM word, captured with the same enable as w_data.
   always_comb begin
      popcnt_d = popcnt_q;
      if (load) begin
         popcnt_d = '0;
         for (int i = 0; i < WIDTH_D; i++) popcnt_d = popcnt_d + 6'(rom_coef[i]);
      end
   end

   // Popcount register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) popcnt_q <= '0;
      else        popcnt_q <= popcnt_d;
   end

   assign w_popcnt = popcnt_q;
`endif

   assign rom_addr = rom_addr_q;
   assign w_data   = w_data_q;
   assign w_valid  = w_valid_q;
   assign w_last   = w_last_q;
   assign done     = done_q;
   assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_fw_weight_seq.sv
// Self-checking bench for fw_weight_seq: directed jobs plus randomized jobs
// compared against a queue-based model of the expected word stream.
module tb_fw_weight_seq;

   localparam int WA = 12;
   localparam int DP = 80;
   localparam int WD = 40;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [WA-1:0] base_addr = '0;
   logic [WA-1:0] num_words = '0;
   logic [7:0]    num_passes = '0;
   logic [WA-1:0] rom_addr;
   logic [WD-1:0] rom_coef;
   logic [WD-1:0] w_data;
   logic          w_valid;
   logic          w_ready = 1'b0;
   logic          w_last;
   logic          busy;
   logic          done;
`ifdef FW_SEQ_POPCNT_EN
   logic [5:0]    w_popcnt;
`endif

   int total = 0;
   int passed = 0;
   int fails = 0;
   bit pc_mode = 1'b0;

   fw_weight_seq #(.WIDTH_A(WA), .DEPTH(DP), .WIDTH_D(WD)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .base_addr(base_addr), .num_words(num_words), .num_passes(num_passes),
      .rom_addr(rom_addr), .rom_coef(rom_coef),
      .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready), .w_last(w_last),
      .busy(busy), .done(done)
`ifdef FW_SEQ_POPCNT_EN
      , .w_popcnt(w_popcnt)
`endif
   );

   always #5 clk = ~clk;

   // Bench ROM: address echo, or three popcount patterns at addresses 0..2.
   function automatic logic [WD-1:0] rom_word(input int a);
      if (pc_mode && a == 0) return 40'hFFFFFFFFFF;
      if (pc_mode && a == 1) return 40'h0;
      if (pc_mode && a == 2) return 40'h0000000F01;
      return {28'h0, 12'(a)};
   endfunction

   always_comb rom_coef = rom_word(int'(rom_addr));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready.
   // junk: hammer start/config while busy; it must be ignored.
   task automatic run_job(input int base, input int words, input int passes,
                          input int mode, input bit junk);
      logic [WD-1:0] exp_q[$];
      bit            last_q[$];
      int            n, cyc, hs;
      bit            stall;
      logic [WD-1:0] held;
      bit            held_last;
      bit            pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      for (int p = 0; p < passes; p++)
         for (int i = 0; i < words; i++) begin
            exp_q.push_back(rom_word(((base % DP) + i) % DP));
            last_q.push_back(i == words - 1);
         end
      n = exp_q.size();
      @(negedge clk);
      base_addr = WA'(base); num_words = WA'(words); num_passes = 8'(passes);
      start = 1'b1; w_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      chk("lat_valid0", w_valid, 0);
      chk("lat_busy", busy, 1);
      chk("lat_addr", rom_addr, base % DP);
      cyc = 0; hs = 0; stall = 0; held = '0; held_last = 0;
      forever begin
         case (mode)
            0:       w_ready = 1'b1;
            1:       w_ready = pat[cyc % 4];
            default: w_ready = ($urandom % 4) != 0;
         endcase
         if (junk) begin
            start = 1'($urandom); base_addr = WA'($urandom);
            num_words = WA'($urandom); num_passes = 8'($urandom);
         end
         if (stall) begin
            chk("stall_valid", w_valid, 1);
            chk("stall_data", w_data, held);
            chk("stall_last", w_last, held_last);
         end
         chk("no_early_done", done, 0);
         if (w_valid && w_ready) begin
            chk("data", w_data, exp_q.pop_front());
            chk("last", w_last, last_q.pop_front());
`ifdef FW_SEQ_POPCNT_EN
            chk("popcnt", w_popcnt, $countones(w_data));
`endif
            hs++;
         end
         stall = w_valid && !w_ready;
         held = w_data; held_last = w_last;
         if (exp_q.size() == 0) break;
         if (cyc >= 400) begin
            chk("timeout", 1, 0);
            break;
         end
         @(negedge clk);
         cyc++;
      end
      @(negedge clk);
      start = 1'b0; w_ready = 1'b0;
      chk("handshakes", hs, n);
      if (mode == 0) chk("gapless", cyc, n);
      chk("done_pulse", done, 1);
      chk("end_valid", w_valid, 0);
      chk("end_last", w_last, 0);
      chk("end_busy", busy, 0);
      @(negedge clk);
      chk("done_once", done, 0);
      chk("no_extra_valid", w_valid, 0);
   endtask

   initial begin
      // reset state
      #12;
      chk("rst_addr", rom_addr, 0);
      chk("rst_data", w_data, 0);
      chk("rst_valid", w_valid, 0);
      chk("rst_last", w_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
`ifdef FW_SEQ_POPCNT_EN
      chk("rst_popcnt", w_popcnt, 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      // two passes of three words, always ready
      run_job(5, 3, 2, 0, 0);
      // window wrapping past the ROM end
      run_job(78, 4, 1, 0, 0);
      // same window with a stalling consumer
      run_job(78, 4, 1, 1, 0);
      // base beyond DEPTH folds back
      run_job(165, 3, 1, 0, 0);

      // empty jobs: done next cycle, nothing emitted
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         base_addr = 12'd3;
         num_words  = (k == 0) ? 12'd0 : 12'd4;
         num_passes = (k == 0) ? 8'd3 : 8'd0;
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         chk("empty_done", done, 1);
         chk("empty_busy", busy, 0);
         chk("empty_valid", w_valid, 0);
         @(negedge clk);
         chk("empty_done_once", done, 0);
         chk("empty_valid2", w_valid, 0);
      end

      // abort on the second word, with ready high in the same cycle
      @(negedge clk);
      base_addr = 12'd10; num_words = 12'd5; num_passes = 8'd2;
      start = 1'b1; w_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("ab_w1_valid", w_valid, 1);
      chk("ab_w1_data", w_data, 10);
      @(negedge clk);
      chk("ab_w2_data", w_data, 11);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0; w_ready = 1'b0;
      chk("ab_valid", w_valid, 0);
      chk("ab_busy", busy, 0);
      chk("ab_done", done, 0);
      @(negedge clk);
      chk("ab_done2", done, 0);

      // reset mid-job clears outputs immediately
      @(negedge clk);
      base_addr = 12'd20; num_words = 12'd6; num_passes = 8'd2;
      start = 1'b1; w_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_valid", w_valid, 0);
      chk("mrst_data", w_data, 0);
      chk("mrst_addr", rom_addr, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_last", w_last, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("mrst_idle", busy, 0);
      run_job(5, 3, 2, 0, 0);

      // randomized jobs with a random consumer and busy-time start noise
      for (int j = 0; j < 8; j++)
         run_job($urandom_range(0, 200), $urandom_range(1, 6),
                 $urandom_range(1, 3), 2, 1);

`ifdef FW_SEQ_POPCNT_EN
      pc_mode = 1'b1;
      run_job(0, 3, 1, 0, 0);
      pc_mode = 1'b0;
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/fw_weight_seq.md
FW_WEIGHT_SEQ -- requirements
Module: fw_weight_seq

Interface
REQ-001 SHALL have parameter: WIDTH_A, 12, weight-ROM address width.
REQ-002 SHALL have parameter: DEPTH, 80, number of valid ROM words; addresses 0..DEPTH-1.
REQ-003 SHALL have parameter: WIDTH_D, 40, ROM word width (one binary-weight row).
REQ-004 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port: start  input  1  begin a job; sampled only in IDLE.
REQ-007 SHALL have port: abort  input  1  synchronous cancel of the current job.
REQ-008 SHALL have port: base_addr  input  WIDTH_A  first ROM address; latched on accepted start.
REQ-009 SHALL have port: num_words  input  WIDTH_A  words per pass; latched on accepted start.
REQ-010 SHALL have port: num_passes  input  8  pass count; latched on accepted start.
REQ-011 SHALL have port: rom_addr  output  WIDTH_A  registered address to the combinational weight ROM.
REQ-012 SHALL have port: rom_coef  input  WIDTH_D  ROM data for rom_addr, same cycle.
REQ-013 SHALL have port: w_data  output  WIDTH_D  registered weight word to the downstream consumer.
REQ-014 SHALL have port: w_valid  output  1  w_data valid.
REQ-015 SHALL have port: w_ready  input  1  consumer accepts w_data when w_valid and w_ready are both high.
REQ-016 SHALL have port: w_last  output  1  high with the last word of each pass.
REQ-017 SHALL have port: busy  output  1  high in any state other than IDLE.
REQ-018 SHALL have port: done  output  1  one-cycle pulse at normal job completion.
REQ-019 SHALL have port: w_popcnt  output  6  number of ones in w_data; present only with FW_SEQ_POPCNT_EN.

Function
REQ-020 SHALL implement the FSM IDLE -> RUN -> DRAIN -> IDLE.
REQ-021 IDLE: start=1 with num_words!=0 and num_passes!=0 SHALL latch the configuration, set rom_addr=base_addr and go to RUN.
REQ-022 IDLE: start=1 with num_words==0 or num_passes==0 SHALL pulse done on the next cycle, issue no words and stay in IDLE.
REQ-023 RUN: when the output slot is free (!w_valid or w_ready), SHALL load w_data=rom_coef, set w_valid=1 and advance rom_addr.
REQ-024 Latency: the first w_valid SHALL rise on the 2nd rising edge after start is sampled; throughput SHALL be 1 word/cycle while w_ready=1.
REQ-025 rom_addr SHALL wrap from DEPTH-1 to 0; base_addr>=DEPTH SHALL be reduced modulo DEPTH when latched.
REQ-026 At the end of a pass, rom_addr SHALL reload base_addr, the pass counter SHALL increment, and the next word SHALL follow with no bubble.
REQ-027 w_last SHALL be high exactly when the pass-word counter equals num_words-1 for the word in w_data.
REQ-028 After the final word of the final pass is loaded, the FSM SHALL enter DRAIN and wait for the handshake.
REQ-029 DRAIN: on the handshake, SHALL drop w_valid, pulse done for one cycle and return to IDLE.
REQ-030 While w_valid=1 and w_ready=0, w_data, w_last and w_valid SHALL stay stable; a word SHALL never be retracted or duplicated.
REQ-031 abort=1 in RUN or DRAIN SHALL, on the next edge, go to IDLE and clear w_valid, with no done pulse; abort SHALL have priority over the handshake in the same cycle.
REQ-032 start while busy SHALL be ignored, and configuration inputs SHALL have no effect until the next accepted start.

Reset
REQ-033 rst_n=0 SHALL asynchronously force IDLE, rom_addr=0, w_data=0, w_valid=0, w_last=0, busy=0, done=0 (w_popcnt=0), and clear all counters.
REQ-034 Reset asserted mid-job SHALL discard the job; after release the block SHALL be idle and accept a new start.

Configuration
REQ-035 With FW_SEQ_POPCNT_EN defined, w_popcnt SHALL be registered alongside w_data, use the same load enable, and equal popcount(rom_coef) at load.
REQ-036 Without FW_SEQ_POPCNT_EN, the w_popcnt port and its logic SHALL be absent; all other behaviour SHALL be unchanged.

Verification
REQ-037 Bench ROM returns {28'h0,addr}; base=5, words=3, passes=2, w_ready=1 -> w_data 5,6,7,5,6,7 on consecutive cycles; w_last on the 3rd and 6th words; done one cycle after the 6th word.
REQ-038 base=78, words=4, passes=1 -> addresses 78,79,0,1.
REQ-039 Same job as REQ-038, with w_ready toggling 1,0,0,1 -> each word held stable while stalled; exactly 4 handshakes, no loss or duplication.
REQ-040 words=0, start pulse -> done the next cycle, w_valid never asserted, busy stays 0.
REQ-041 abort on the 2nd word -> w_valid=0 next cycle, no done; rst_n low mid-job -> all outputs 0 immediately; a following start runs normally.
REQ-042 With FW_SEQ_POPCNT_EN, ROM words 40'hFFFFFFFFFF, 40'h0, 40'h0000000F01 -> w_popcnt 40, 0, 5.
